// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM state type and counter width helper for osc_freq_meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: synchronizes an asynchronous pulse and strobes one cycle per rising edge.
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/osc_freq_meter.sv
// osc_freq_meter: enables an oscillator, settles, then counts its edges over a fixed gate window.
module osc_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             pulse_in,
    output logic             osc_enable,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int GW = cnt_w(GATE_CYCLES);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam logic [GW-1:0] GATE_LD = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic [GW-1:0] gcnt;
    logic [SW-1:0] scnt;
    logic [CNT_W-1:0] ecnt, ecnt_nx;
    logic sat, sat_nx, rise;

    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .async_in(pulse_in),
        .edge_out(rise)
    );

    // Count saturates; an edge arriving while already saturated marks the result as overflowed.
    always_comb begin
        ecnt_nx = (rise && ecnt != CNT_MAX) ? ecnt + CNT_W'(1) : ecnt;
        sat_nx  = sat | (rise && ecnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gcnt        <= '0;
            scnt        <= '0;
            ecnt        <= '0;
            sat         <= 1'b0;
            osc_enable  <= 1'b0;
            busy        <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= SETTLE;
                    scnt       <= SETTLE_LD;
                    ecnt       <= '0;
                    sat        <= 1'b0;
                    osc_enable <= 1'b1;
                    busy       <= 1'b1;
                end
                SETTLE: if (scnt == '0) begin
                    state <= GATE;
                    gcnt  <= GATE_LD;
                end else begin
                    scnt <= scnt - SW'(1);
                end
                GATE: begin
                    ecnt <= ecnt_nx;
                    sat  <= sat_nx;
                    if (gcnt == '0) begin
                        state       <= DONE;
                        count       <= ecnt_nx;
                        overflow    <= sat_nx;
                        count_valid <= 1'b1;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                DONE: if (continuous) begin
                    state <= GATE;
                    gcnt  <= GATE_LD;
                    ecnt  <= '0;
                    sat   <= 1'b0;
                end else begin
                    state      <= IDLE;
                    osc_enable <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: scoreboard bench for two meter instances (16-bit and 4-bit counters).
`timescale 1ns/1ps
module tb_osc_freq_meter;

    typedef struct {
        int cnt;
        int ovf;
        int tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse_in = 1'b0;
    logic start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
    logic osc_a, busy_a, cv_a, ovf_a, osc_b, busy_b, cv_b, ovf_b;
    logic [15:0] count_a;
    logic [3:0] count_b;

    int half = 0;
    int cyc = 0;
    int total = 0;
    int passed = 0;
    int strobes_a = 0, strobes_b = 0;
    int last_cyc = 0, prev_cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    osc_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(16), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .pulse_in(pulse_in),
        .osc_enable(osc_a), .busy(busy_a), .count(count_a), .count_valid(cv_a), .overflow(ovf_a)
    );

    osc_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(16), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .pulse_in(pulse_in),
        .osc_enable(osc_b), .busy(busy_b), .count(count_b), .count_valid(cv_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse edges land on times ending in 2 or 7 ns, never on a clock edge.
    initial begin
        #2;
        forever begin
            if (half == 0) begin
                pulse_in = 1'b0;
                #10;
            end else begin
                #(half) pulse_in = ~pulse_in;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation time exceeded limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic score(input string name, input int act, input int exp, input int tol);
        total++;
        if (act >= exp - tol && act <= exp + tol) passed++;
        else $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cv_a) begin
            strobes_a++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            if (qa.size() == 0) begin
                check("a_unexpected_strobe", 1, 0);
            end else begin
                e = qa.pop_front();
                score("a_count", int'(count_a), e.cnt, e.tol);
                check("a_overflow", int'(ovf_a), e.ovf);
            end
        end
        if (cv_b) begin
            strobes_b++;
            if (qb.size() == 0) begin
                check("b_unexpected_strobe", 1, 0);
            end else begin
                e = qb.pop_front();
                score("b_count", int'(count_b), e.cnt, e.tol);
                check("b_overflow", int'(ovf_b), e.ovf);
            end
        end
    end

    task automatic push_a(input int c, input int o, input int t);
        exp_t e;
        e.cnt = c; e.ovf = o; e.tol = t;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int o, input int t);
        exp_t e;
        e.cnt = c; e.ovf = o; e.tol = t;
        qb.push_back(e);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_a(input int target, input int budget);
        int n = 0;
        while (strobes_a < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("a_strobe_wait", int'(strobes_a >= target), 1);
    endtask

    task automatic wait_b(input int target, input int budget);
        int n = 0;
        while (strobes_b < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("b_strobe_wait", int'(strobes_b >= target), 1);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_osc_enable"}, int'(osc_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_count"}, int'(count_a), 0);
        check({tag, "_count_valid"}, int'(cv_a), 0);
        check({tag, "_overflow"}, int'(ovf_a), 0);
    endtask

    initial begin
        int lat;
        int s0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_a_zero("reset_a");
        check("reset_b_count", int'(count_b), 0);
        check("reset_b_busy", int'(busy_b), 0);

        // Basic measurement: 100 ns period, 10 edges in a 100-cycle gate.
        half = 50;
        push_a(10, 0, 1);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check("a_osc_enable_rise", int'(osc_a), 1);
        check("a_busy_rise", int'(busy_a), 1);
        lat = 1;
        while (!cv_a && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("a_latency", lat, 117);
        @(negedge clk);
        check("a_busy_after", int'(busy_a), 0);
        check("a_osc_after", int'(osc_a), 0);
        check("a_cv_single", int'(cv_a), 0);

        // Oscillator silent.
        half = 0;
        repeat (10) @(negedge clk);
        s0 = strobes_a;
        push_a(0, 0, 0);
        pulse_start_a();
        wait_a(s0 + 1, 300);
        repeat (10) @(negedge clk);
        check("a_silent_strobes", strobes_a, s0 + 1);
        check("a_silent_osc", int'(osc_a), 0);

        // 4-bit counter: 25 edges saturate, then 5 edges fit.
        half = 20;
        repeat (10) @(negedge clk);
        push_b(15, 1, 0);
        pulse_start_b();
        wait_b(1, 300);
        half = 100;
        repeat (10) @(negedge clk);
        push_b(5, 0, 0);
        pulse_start_b();
        wait_b(2, 300);
        repeat (5) @(negedge clk);
        check("b_count_held", int'(count_b), 5);
        check("b_busy_after", int'(busy_b), 0);

        // Continuous mode at 50 ns period.
        half = 25;
        repeat (10) @(negedge clk);
        s0 = strobes_a;
        cont_a = 1'b1;
        push_a(20, 0, 1);
        push_a(20, 0, 1);
        push_a(20, 0, 1);
        pulse_start_a();
        wait_a(s0 + 2, 400);
        check("cont_interval", last_cyc - prev_cyc, 101);
        @(negedge clk);
        check("cont_osc_high", int'(osc_a), 1);
        check("cont_busy_high", int'(busy_a), 1);
        repeat (40) @(negedge clk);
        cont_a = 1'b0;
        wait_a(s0 + 3, 200);
        check("cont_last_interval", last_cyc - prev_cyc, 101);
        repeat (20) @(negedge clk);
        check("cont_strobes", strobes_a, s0 + 3);
        check("cont_idle_busy", int'(busy_a), 0);
        check("cont_idle_osc", int'(osc_a), 0);

        // Reset mid-gate after about 7 edges discards the run.
        half = 50;
        repeat (10) @(negedge clk);
        s0 = strobes_a;
        pulse_start_a();
        repeat (90) @(negedge clk);
        check("pre_rst_busy", int'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_a_zero("mid_rst");
        repeat (150) @(negedge clk);
        check("rst_no_strobe", strobes_a, s0);
        push_a(10, 0, 1);
        pulse_start_a();
        wait_a(s0 + 1, 300);

        // Starts while busy are ignored.
        repeat (5) @(negedge clk);
        s0 = strobes_a;
        push_a(10, 0, 1);
        pulse_start_a();
        for (int i = 0; i < 6; i++) begin
            repeat (13) @(negedge clk);
            pulse_start_a();
        end
        wait_a(s0 + 1, 300);
        repeat (20) @(negedge clk);
        check("busy_start_strobes", strobes_a, s0 + 1);
        check("busy_start_idle", int'(busy_a), 0);

        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
